pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives en/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the PC enable and the stopread suppress bit.
- Inputs: cache hits, MEM-stage request/branch/halt fields (EX/MEM _o side), and ID/EX and IF/ID register fields for load-use detection.
- Holds pipeline state across multi-cycle memory waits and the halt sequence.

---
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Decides each cycle whether the pipe advances, freezes, inserts a load-use
// bubble or flushes behind a taken branch, and tracks the halt sequence.
module pipeline_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic             mem_halt,
   input  logic             mem_br_taken,
   input  logic             ex_dREN,
   input  logic [4:0]       ex_wsel,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             stopread,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt
);

   // DDONE: data access already finished, still waiting on the fetch side.
   typedef enum logic [1:0] {RUN, DDONE, HALTED} state_t;

   state_t state, next_state;
   logic   mem_req, advance, load_use, stall;

   assign mem_req  = mem_dREN | mem_dWEN;
   // In DDONE the data half is already satisfied, so only ihit gates progress.
   assign advance  = ihit & (~mem_req | dhit | (state == DDONE));
   assign load_use = ex_dREN & (ex_wsel != 5'd0) &
                     ((ex_wsel == id_rs) | (ex_wsel == id_rt));
   // A lost cycle is either a full freeze or a load-use bubble that a taken
   // branch does not override.
   assign stall    = (state != HALTED) &
                     (~advance | (~mem_br_taken & load_use));

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= RUN;
      else     state <= next_state;
   end

   // Next-state and latch-control decode; everything low while reset is held.
   always_comb begin
      next_state  = state;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      stopread    = 1'b0;
      case (state)
         RUN: begin
            if (mem_req & dhit & ~ihit)  next_state = DDONE;
            else if (mem_halt & advance) next_state = HALTED;
         end
         DDONE: begin
            stopread = 1'b1;
            if (ihit) next_state = mem_halt ? HALTED : RUN;
         end
         HALTED: next_state = HALTED;
         default: next_state = RUN;
      endcase
      if ((state != HALTED) && advance) begin
         if (mem_br_taken) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end else if (load_use) begin
            // Hold PC and IF/ID, let EX onward drain, bubble into ID/EX.
            idex_en     = 1'b1;
            idex_flush  = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
         end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
         end
      end
      if (RST) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         ifid_flush  = 1'b0;
         idex_flush  = 1'b0;
         exmem_flush = 1'b0;
         stopread    = 1'b0;
      end
   end

   // Registered halt flag, set on the cycle the FSM enters HALTED.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) halt <= 1'b0;
      else     halt <= (next_state == HALTED);
   end

   // Saturating count of cycles lost to freezes and load-use bubbles.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                            stall_cnt <= '0;
      else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random
// traffic, compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;
   localparam int CNT_W = 16;
   localparam int VW    = 9 + 1 + CNT_W;

   logic CLK = 1'b0;
   logic RST, ihit, dhit, mem_dREN, mem_dWEN, mem_halt, mem_br_taken, ex_dREN;
   logic [4:0] ex_wsel, id_rs, id_rt;
   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_flush, exmem_flush, stopread, halt;
   logic [CNT_W-1:0] stall_cnt;

   int vecs = 0;
   int miss = 0;

   // Model: pipeline halted, data side finished while waiting on fetch, lost cycles.
   bit             m_halt, m_dd;
   int unsigned    m_cnt;

   pipeline_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
      .mem_br_taken(mem_br_taken), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
      .id_rs(id_rs), .id_rt(id_rt), .pc_en(pc_en), .ifid_en(ifid_en),
      .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .stopread(stopread), .halt(halt),
      .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   function automatic logic [VW-1:0] got_vec();
      return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, exmem_flush, stopread, halt, stall_cnt};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [8:0] o;
      bit req, adv, lu;
      req = mem_dREN | mem_dWEN;
      adv = ihit && (!req || dhit || m_dd);
      lu  = ex_dREN && ex_wsel != 0 && (ex_wsel == id_rs || ex_wsel == id_rt);
      o = 9'b0;
      if (!RST && !m_halt) begin
         if (adv) begin
            if (mem_br_taken) o = 9'b11111_1110;
            else if (lu)      o = 9'b00111_0100;
            else              o = 9'b11111_0000;
         end
         o[0] = m_dd;
      end
      return {o, m_halt, CNT_W'(m_cnt)};
   endfunction

   task automatic model_reset();
      m_halt = 0; m_dd = 0; m_cnt = 0;
   endtask

   // One clock of the specified behaviour, using the inputs currently driven.
   task automatic model_step();
      bit req, adv, lu;
      if (RST) begin model_reset(); return; end
      if (m_halt) return;
      req = mem_dREN | mem_dWEN;
      adv = ihit && (!req || dhit || m_dd);
      lu  = ex_dREN && ex_wsel != 0 && (ex_wsel == id_rs || ex_wsel == id_rt);
      if ((!adv || (lu && !mem_br_taken)) && m_cnt < (2**CNT_W - 1)) m_cnt++;
      if (adv && mem_halt)               begin m_halt = 1; m_dd = 0; end
      else if (m_dd && ihit)             m_dd = 0;
      else if (!m_dd && req && dhit && !ihit) m_dd = 1;
   endtask

   task automatic apply(input logic r, ih, dh, rd, wr, mh, br, exr,
                        input logic [4:0] ew, rs, rt);
      RST = r; ihit = ih; dhit = dh; mem_dREN = rd; mem_dWEN = wr;
      mem_halt = mh; mem_br_taken = br; ex_dREN = exr;
      ex_wsel = ew; id_rs = rs; id_rt = rt;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      tick();
   endtask

   task automatic test_reset();
      apply(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      vecs++;
      if (got_vec() !== exp_vec()) begin
         miss++; $display("FAIL reset_outputs: got %h want %h", got_vec(), exp_vec());
      end
      vecs++;
      if ({halt, stall_cnt} !== {1'b0, CNT_W'(0)}) begin
         miss++; $display("FAIL reset_state: got %b/%0d want 0/0", halt, stall_cnt);
      end
      tick();
   endtask

   task automatic test_straight();
      for (int i = 0; i < 10; i++) begin
         apply(0, 1, 0, 0, 0, 0, 0, 0, 5'd3, 5'd1, 5'd2);
         vecs++;
         if (got_vec() !== exp_vec()) begin
            miss++; $display("FAIL straight[%0d]: got %h want %h", i, got_vec(), exp_vec());
         end
         tick();
      end
      vecs++;
      if (stall_cnt !== 0) begin
         miss++; $display("FAIL straight_cnt: got %0d want 0", stall_cnt);
      end
   endtask

   task automatic test_dwait();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(0, 1, (i == 3), 1, 0, 0, 0, 0, 0, 0, 0);
         vecs++;
         if (got_vec() !== exp_vec()) begin
            miss++; $display("FAIL dwait[%0d]: got %h want %h", i, got_vec(), exp_vec());
         end
         tick();
      end
      vecs++;
      if (stall_cnt !== CNT_W'(3)) begin
         miss++; $display("FAIL dwait_cnt: got %0d want 3", stall_cnt);
      end
   endtask

   task automatic test_ddone();
      for (int i = 0; i < 5; i++) begin
         apply(0, (i >= 3), 1, 1, 0, 0, 0, 0, 0, 0, 0);
         vecs++;
         if (got_vec() !== exp_vec()) begin
            miss++; $display("FAIL ddone[%0d]: got %h want %h", i, got_vec(), exp_vec());
         end
         if (i == 1 || i == 2) begin
            vecs++;
            if (stopread !== 1'b1) begin
               miss++; $display("FAIL ddone_stopread[%0d]: got %b want 1", i, stopread);
            end
         end
         tick();
      end
   endtask

   task automatic test_load_use();
      for (int i = 0; i < 3; i++) begin
         // i=0: hazard on rt; i=1: wsel=0 never stalls; i=2: hazard on rs
         apply(0, 1, 0, 0, 0, 0, 0, 1, (i == 1) ? 5'd0 : 5'd8,
               (i == 2) ? 5'd8 : 5'd0, (i == 0) ? 5'd8 : 5'd0);
         vecs++;
         if (got_vec() !== exp_vec()) begin
            miss++; $display("FAIL load_use[%0d]: got %h want %h", i, got_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_branch_lu();
      apply(0, 1, 0, 0, 0, 0, 1, 1, 5'd8, 5'd8, 5'd8);
      vecs++;
      if (got_vec() !== exp_vec()) begin
         miss++; $display("FAIL branch_lu: got %h want %h", got_vec(), exp_vec());
      end
      tick();
   endtask

   task automatic test_halt();
      for (int i = 0; i < 4; i++) begin
         apply(0, 1, 0, 0, 0, (i == 0), 0, 0, 0, 0, 0);
         vecs++;
         if (got_vec() !== exp_vec()) begin
            miss++; $display("FAIL halt[%0d]: got %h want %h", i, got_vec(), exp_vec());
         end
         tick();
      end
      vecs++;
      if ({halt, pc_en, memwb_en} !== 3'b100) begin
         miss++; $display("FAIL halted_freeze: got %b want 100", {halt, pc_en, memwb_en});
      end
      do_reset();
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs++;
      if (got_vec() !== exp_vec()) begin
         miss++; $display("FAIL halt_reset: got %h want %h", got_vec(), exp_vec());
      end
      tick();
   endtask

   task automatic test_async_reset();
      apply(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      tick();
      apply(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      vecs++;
      if (stopread !== 1'b1) begin
         miss++; $display("FAIL async_pre: got stopread %b want 1", stopread);
      end
      RST = 1'b1;
      model_reset();
      #1;
      vecs++;
      if (got_vec() !== exp_vec()) begin
         miss++; $display("FAIL async_reset: got %h want %h", got_vec(), exp_vec());
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)));
         if (RST) model_reset();
         vecs++;
         if (got_vec() !== exp_vec()) begin
            miss++; $display("FAIL random[%0d]: got %h want %h", i, got_vec(), exp_vec());
         end
         tick();
      end
   endtask

   initial begin
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      @(negedge CLK);
      test_reset();
      test_straight();
      test_dwait();
      test_ddone();
      test_load_use();
      test_branch_lu();
      test_halt();
      test_async_reset();
      do_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
